// File: rtl/mc_main_control.sv
// mc_main_control: multi-cycle MIPS main control FSM; ADDI support is built only when MC_ADDI_EN is defined.
// Control outputs decode from the state register (all 0 in reset); FETCH, MEM_READ and MEM_WRITE stall until mem_ready.
module mc_main_control #(
    parameter logic [5:0] OP_RTYPE = 6'd0,
    parameter logic [5:0] OP_LW    = 6'd35,
    parameter logic [5:0] OP_SW    = 6'd43,
    parameter logic [5:0] OP_BEQ   = 6'd4,
    parameter logic [5:0] OP_J     = 6'd2,
    parameter logic [5:0] OP_ADDI  = 6'd8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   bad_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        illegal_d     = illegal_q;
        bad_op        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALU speculatively forms the branch target while the opcode is decoded.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EXEC;
`else
                    OP_ADDI:      bad_op  = 1'b1;
`endif
                    default:      bad_op  = 1'b1;
                endcase
                if (bad_op) begin
                    state_d    = S_FETCH;
                    illegal_d  = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_LW)      state_d = S_MEM_READ;
                else if (opcode == OP_SW) state_d = S_MEM_WRITE;
                else                      state_d = S_FETCH;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
`ifdef MC_ADDI_EN
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    assign state      = state_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for mc_main_control: per-cycle expected state/controls queued at drive time, compared at negedge.
module tb_mc_main_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    typedef struct {
        logic [3:0]  st;
        logic [16:0] ctl;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic exp_ill;

    mc_main_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .instr_done(instr_done),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    wire [16:0] dut_ctl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                           pc_source, instr_done};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Expected control word from the state table; bad is the illegal-opcode instr_done in DECODE.
    function automatic logic [16:0] exp_ctl(input int st, input logic mr, input logic bad);
        logic pw, pwc, io, mrd, mwr, irw, rd, m2r, rw, sa, dn;
        logic [1:0] sb, ao, ps;
        {pw, pwc, io, mrd, mwr, irw, rd, m2r, rw, sa, dn} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            1:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            2:  begin sb = 2'b11; dn = bad; end
            3:  begin sa = 1; sb = 2'b10; end
            4:  begin mrd = 1; io = 1; end
            5:  begin rw = 1; m2r = 1; dn = 1; end
            6:  begin mwr = 1; io = 1; dn = mr; end
            7:  begin sa = 1; ao = 2'b10; end
            8:  begin rw = 1; rd = 1; dn = 1; end
            9:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; dn = 1; end
            10: begin pw = 1; ps = 2'b10; dn = 1; end
            11: begin sa = 1; sb = 2'b10; end
            12: begin rw = 1; dn = 1; end
            default: ;
        endcase
        return {pw, pwc, io, mrd, mwr, irw, rd, m2r, rw, sa, sb, ao, ps, dn};
    endfunction

    task automatic step(input int st, input logic mr, input logic [5:0] op, input logic bad);
        exp_t e;
        @(posedge clk);
        #1;
        mem_ready = mr;
        opcode    = op;
        exp_q.push_back('{st: 4'(st), ctl: exp_ctl(st, mr, bad), ill: exp_ill});
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("state", {28'd0, state}, {28'd0, e.st});
            chk("ctl", {15'd0, dut_ctl}, {15'd0, e.ctl});
            chk("illegal_op", {31'd0, illegal_op}, {31'd0, e.ill});
            chk("rd_wr_excl", {31'd0, mem_read & mem_write}, 32'd0);
        end
    endtask

    function automatic logic [5:0] rnd_op();
        return 6'($urandom_range(0, 63));
    endfunction

    task automatic do_instr(input logic [5:0] op, input int fw, input int mw);
        logic legal;
        for (int i = 0; i < fw; i++) step(1, 1'b0, rnd_op(), 1'b0);
        step(1, 1'b1, rnd_op(), 1'b0);
        legal = (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd4) || (op == 6'd2);
`ifdef MC_ADDI_EN
        legal = legal || (op == 6'd8);
`endif
        step(2, 1'b1, op, !legal);
        if (!legal) begin
            exp_ill = 1'b1;
            return;
        end
        case (op)
            6'd0:  begin step(7, 1'b1, rnd_op(), 1'b0); step(8, 1'b1, rnd_op(), 1'b0); end
            6'd35: begin
                step(3, 1'b1, op, 1'b0);
                for (int i = 0; i < mw; i++) step(4, 1'b0, rnd_op(), 1'b0);
                step(4, 1'b1, rnd_op(), 1'b0);
                step(5, 1'b1, rnd_op(), 1'b0);
            end
            6'd43: begin
                step(3, 1'b1, op, 1'b0);
                for (int i = 0; i < mw; i++) step(6, 1'b0, rnd_op(), 1'b0);
                step(6, 1'b1, rnd_op(), 1'b0);
            end
            6'd4:  step(9, 1'b1, rnd_op(), 1'b0);
            6'd2:  step(10, 1'b1, rnd_op(), 1'b0);
            default: begin step(11, 1'b1, rnd_op(), 1'b0); step(12, 1'b1, rnd_op(), 1'b0); end
        endcase
    endtask

    // Release reset just after a rising edge so the IDLE cycle is observable.
    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back('{st: 4'd0, ctl: 17'd0, ill: 1'b0});
        @(negedge clk);
        begin
            exp_t e;
            e = exp_q.pop_front();
            chk("idle_state", {28'd0, state}, {28'd0, e.st});
            chk("idle_ctl", {15'd0, dut_ctl}, {15'd0, e.ctl});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [5] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2};
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'd0; exp_ill = 1'b0;
        #12;
        chk("rst_state", {28'd0, state}, 32'd0);
        chk("rst_ctl", {15'd0, dut_ctl}, 32'd0);
        chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
        release_reset();

        do_instr(6'd0, 0, 0);
        do_instr(6'd35, 1, 2);
        do_instr(6'd43, 0, 0);
        do_instr(6'd4, 0, 0);
        do_instr(6'd2, 0, 0);
        do_instr(6'd63, 0, 0);
        do_instr(6'd0, 0, 0);
        do_instr(6'd8, 0, 0);
        do_instr(6'd35, 0, 0);

        // Abort a stalled store with an asynchronous reset.
        step(1, 1'b1, rnd_op(), 1'b0);
        step(2, 1'b1, 6'd43, 1'b0);
        step(3, 1'b1, 6'd43, 1'b0);
        step(6, 1'b0, rnd_op(), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_state", {28'd0, state}, 32'd0);
        chk("abort_ctl", {15'd0, dut_ctl}, 32'd0);
        chk("abort_illegal", {31'd0, illegal_op}, 32'd0);
        @(negedge clk);
        chk("abort_hold_state", {28'd0, state}, 32'd0);
        chk("abort_hold_mem_write", {31'd0, mem_write}, 32'd0);
        exp_ill = 1'b0;
        release_reset();
        do_instr(6'd43, 0, 0);

        for (int n = 0; n < 40; n++)
            do_instr(ops[$urandom_range(0, 4)], $urandom_range(0, 2), $urandom_range(0, 2));
        do_instr(6'd4, 0, 0);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
